// File: rtl/alt_compr_pkg.sv
// Shared definitions for the alternating-compressor input conditioning and controller.
// Channel indices double as arbitration priority: lower index wins.
package alt_compr_pkg;

    localparam int unsigned NUM_CH           = 3;
    localparam int unsigned CH_PMB           = 0;
    localparam int unsigned CH_PA            = 1;
    localparam int unsigned CH_PB            = 2;
    localparam int unsigned DEB_CYCLES_DEF   = 16;
    localparam int unsigned STUCK_CYCLES_DEF = 1000;

    typedef logic [NUM_CH-1:0] ch_vec_t;

    // Isolate the lowest set bit, i.e. the highest-priority request.
    function automatic ch_vec_t prio_pick(ch_vec_t req);
        return req & (~req + ch_vec_t'(1));
    endfunction

endpackage

// File: rtl/alt_compr_debounce_ch.sv
// One switch channel: 2-flop synchronizer, debounce counter, stable level and a
// registered one-cycle rise strobe.
module alt_compr_debounce_ch #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o
);

    localparam int unsigned    CntW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    logic            s1_q, s2_q;
    logic            stable_q, stable_d;
    logic            rise_q, rise_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        rise_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;

endmodule

// File: rtl/alt_compr_input_cond.sv
// Conditions the three raw compressor switches into mutually exclusive one-cycle pulses.
// Optional stuck-input detection is enabled by defining ALT_COMPR_STUCK_DET_EN.
module alt_compr_input_cond
    import alt_compr_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int unsigned STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic PA_raw,
    input  logic PB_raw,
    input  logic PMB_raw,
    output logic PA,
    output logic PB,
    output logic PMB,
    output logic Busy,
    output logic Fault
);

    ch_vec_t raw, stable, rise;
    ch_vec_t cand, grant;
    ch_vec_t pending_q, pending_d;
    ch_vec_t out_q, out_d;
    logic    busy_q, busy_d;

    assign raw[CH_PMB] = PMB_raw;
    assign raw[CH_PA]  = PA_raw;
    assign raw[CH_PB]  = PB_raw;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        alt_compr_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk_i    (Clk),
            .rst_i    (Reset),
            .raw_i    (raw[ch]),
            .stable_o (stable[ch]),
            .rise_o   (rise[ch])
        );
    end

    // Fresh rises join the pending set in the same cycle so an uncontended rise
    // is issued without an extra cycle of latency.
    always_comb begin
        cand      = pending_q | rise;
        grant     = prio_pick(cand);
        pending_d = cand & ~grant;
        out_d     = grant;
        busy_d    = |pending_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pending_q <= '0;
            out_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
        end
    end

    assign PMB  = out_q[CH_PMB];
    assign PA   = out_q[CH_PA];
    assign PB   = out_q[CH_PB];
    assign Busy = busy_q;

`ifdef ALT_COMPR_STUCK_DET_EN
    localparam int unsigned      StuckW   = $clog2(STUCK_CYCLES + 1);
    localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_CYCLES);

    logic [NUM_CH-1:0][StuckW-1:0] stuck_q, stuck_d;
    logic                          fault_q, fault_d;

    always_comb begin
        stuck_d = stuck_q;
        fault_d = fault_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!stable[ch]) begin
                stuck_d[ch] = '0;
            end else if (stuck_q[ch] != StuckMax) begin
                stuck_d[ch] = stuck_q[ch] + StuckW'(1);
            end
        end
        if (stable == '0) begin
            fault_d = 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (stuck_q[ch] == StuckMax) begin
                    fault_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stuck_q <= '0;
            fault_q <= 1'b0;
        end else begin
            stuck_q <= stuck_d;
            fault_q <= fault_d;
        end
    end

    assign Fault = fault_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{stable, STUCK_CYCLES[0]};
    assign Fault      = 1'b0;
`endif

endmodule
